// File: rtl/fetch_unit_banked_if.sv
// Fetch-unit bus bundle: bank read port, redirect input and the decode
// valid/ready handshake.
//   master : the fetch unit (drives bank_addr and the if_* outputs)
//   slave  : the environment (banks, execute, decode)
interface fetch_unit_banked_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] bank_addr;
  logic [7:0]        b0_data;
  logic [7:0]        b1_data;
  logic [7:0]        b2_data;
  logic [7:0]        b3_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              fetch_fault;

  modport master (
    output bank_addr, if_valid, if_instr, if_pc, fetch_fault,
    input  b0_data, b1_data, b2_data, b3_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  bank_addr, if_valid, if_instr, if_pc, fetch_fault,
    output b0_data, b1_data, b2_data, b3_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit_banked.sv
// Instruction-fetch stage in front of four byte-lane instruction banks.
// Holds the PC, drives one shared word address to all banks, assembles the
// little-endian word and queues {instr, pc} in a 2-entry FIFO toward decode.
// Execute may redirect the PC; a misaligned redirect halts fetch until reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_unit_banked_if.master (banks, redirect, decode handshake)
//   perf_fetch_cnt / perf_stall_cnt : capture and full-stall counters, present
//                only when FETCH_PERF_CNT_EN is defined
module fetch_unit_banked #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_unit_banked_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q;
  logic [1:0][31:0] ent_instr;
  logic [1:0][31:0] ent_pc;
  logic [1:0]       count;
  logic             fault_q;
  logic             run, pop, cap, redir, mis;
  logic [1:0]       wr_idx;
  logic [31:0]      fetch_word;

  assign run        = (state_q == RUN);
  assign mis        = (bus.redirect_pc[1:0] != 2'b00);
  assign redir      = run && bus.redirect_valid;
  assign pop        = bus.if_valid && bus.if_ready;
  // A full buffer can still accept a word in the same cycle the head leaves.
  assign cap        = run && !bus.redirect_valid && ((count != 2'd2) || pop);
  // Tail slot after the (optional) pop has shifted entry 1 down to entry 0.
  assign wr_idx     = count - {1'b0, pop};
  assign fetch_word = {bus.b3_data, bus.b2_data, bus.b1_data, bus.b0_data};

  assign bus.bank_addr   = pc_q[ADDR_W+1:2];
  assign bus.if_valid    = run && (count != 2'd0);
  assign bus.if_instr    = ent_instr[0];
  assign bus.if_pc       = ent_pc[0];
  assign bus.fetch_fault = fault_q;

  always_comb begin
    state_d = state_q;
    if (redir && mis) state_d = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      count     <= 2'd0;
      ent_instr <= '0;
      ent_pc    <= '0;
      fault_q   <= 1'b0;
    end else if (redir) begin
      // Redirect wins over capture and pop; misaligned targets leave pc alone.
      count <= 2'd0;
      if (mis) fault_q <= 1'b1;
      else     pc_q    <= bus.redirect_pc;
    end else begin
      if (pop) begin
        ent_instr[0] <= ent_instr[1];
        ent_pc[0]    <= ent_pc[1];
      end
      // Later NBA overrides the shift when the tail is slot 0.
      if (cap) begin
        ent_instr[wr_idx[0]] <= fetch_word;
        ent_pc[wr_idx[0]]    <= pc_q;
        pc_q                 <= pc_q + 32'd4;
      end
      count <= count + {1'b0, cap} - {1'b0, pop};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (cap)                              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (run && (count == 2'd2) && !pop)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit_banked.sv
// Directed bench for fetch_unit_banked: bank model holds word i = 0x1000_0000+i.
module tb_fetch_unit_banked;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nmis = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  fetch_unit_banked_if #(.ADDR_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  fetch_unit_banked #(.RESET_PC(32'h0), .ADDR_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [31:0] rd_word;
  assign rd_word     = mem[bus.bank_addr];
  assign bus.b0_data = rd_word[7:0];
  assign bus.b1_data = rd_word[15:8];
  assign bus.b2_data = rd_word[23:16];
  assign bus.b3_data = rd_word[31:24];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held for two edges, released 1ns after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"},   {31'd0, bus.if_valid}, 32'd1);
    chk({tag, "_pc"},    bus.if_pc, pc);
    chk({tag, "_instr"}, bus.if_instr, 32'h1000_0000 + {24'd0, pc[9:2]});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // 1: reset state, then streaming at one per cycle
    tick();
    chk("rst_vld",   {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc",    bus.if_pc, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("rst_addr",  {24'd0, bus.bank_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_pfetch", perf_fetch_cnt, 32'd0);
    chk("rst_pstall", perf_stall_cnt, 32'd0);
`endif
    bus.if_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head("t1", 32'(i * 4));
    end

    // 2: backpressure fills the buffer, release keeps order
    do_reset();
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("t2_hold", 32'h0);
    chk("t2_addr", {24'd0, bus.bank_addr}, 32'd2);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_pfetch", perf_fetch_cnt, 32'd2);
    chk("t2_pstall", perf_stall_cnt, 32'd3);
`endif
    bus.if_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_head("t2_rel", 32'(i * 4));
    end

    // 3: aligned redirect with two entries held
    do_reset();
    bus.if_ready = 1'b0;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flush_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("t3_addr", {24'd0, bus.bank_addr}, 32'h10);
    bus.if_ready = 1'b1;
    tick();
    chk_head("t3_new", 32'h40);

    // 4: misaligned redirect halts; later redirects ignored; reset clears
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    chk("t4_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("t4_vld",   {31'd0, bus.if_valid}, 32'd0);
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    chk("t4_vld_hold",   {31'd0, bus.if_valid}, 32'd0);
    chk("t4_fault_hold", {31'd0, bus.fetch_fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_fault", {31'd0, bus.fetch_fault}, 32'd0);

    // 5: bank_addr wrap across 0x3FC -> 0x400
    do_reset();
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3FC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_addr_ff", {24'd0, bus.bank_addr}, 32'hFF);
    tick();
    chk("t5_addr_00", {24'd0, bus.bank_addr}, 32'h00);
    chk_head("t5_3fc", 32'h3FC);
    tick();
    chk_head("t5_400", 32'h400);

    // 6: async reset mid-stream with a full buffer
    do_reset();
    bus.if_ready = 1'b0;
    tick();
    tick();
    chk("t6_pre_vld", {31'd0, bus.if_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_vld",  {31'd0, bus.if_valid}, 32'd0);
    chk("t6_pc",   bus.if_pc, 32'd0);
    chk("t6_addr", {24'd0, bus.bank_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_pfetch", perf_fetch_cnt, 32'd0);
    chk("t6_pstall", perf_stall_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    tick();
    chk_head("t6_restart", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
